// File: rtl/traffic_light_ctrl.sv
// Two-road phase controller driven by the countdown timer's timeout levels.
// Also provides night-mode flashing yellow, a sticky skipped-yellow fault and a cycle counter.
module traffic_light_ctrl #(
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timeout45,
  input  logic             timeout30,
  input  logic             night_mode,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [2:0]       state,
  output logic             seq_fault,
  output logic [CYC_W-1:0] cycles
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    EW_GREEN  = 3'd2,
    EW_YELLOW = 3'd3,
    ALL_RED   = 3'd4,
    NIGHT     = 3'd5
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  state_t cur, nxt;
  logic   t45_q, t30_q;
  logic   blink, blink_nxt;
  logic   fault_set, cyc_inc;
  logic   r45, r30, legal;

  // Only rising edges of the timer levels act, so a held level moves once.
  assign r45   = timeout45 & ~t45_q;
  assign r30   = timeout30 & ~t30_q;
  assign legal = (cur <= NIGHT);
  assign state = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= NS_GREEN;
      t45_q     <= 1'b0;
      t30_q     <= 1'b0;
      blink     <= 1'b0;
      seq_fault <= 1'b0;
      cycles    <= '0;
    end else begin
      cur   <= nxt;
      t45_q <= timeout45;
      t30_q <= timeout30;
      blink <= blink_nxt;
      if (fault_set) seq_fault <= 1'b1;
      if (cyc_inc)   cycles    <= cycles + CYC_W'(1);
    end
  end

  always_comb begin
    nxt       = cur;
    fault_set = 1'b0;
    cyc_inc   = 1'b0;
    blink_nxt = 1'b0;
    if (!legal) begin
      nxt = ALL_RED;
    end else if (r45 && night_mode) begin
      nxt       = NIGHT;
      blink_nxt = 1'b1;
    end else begin
      // r45 is tested before r30 so a same-edge pair resolves to the r45 move.
      case (cur)
        NS_GREEN: begin
          if (r45) begin
            nxt       = EW_GREEN;
            fault_set = 1'b1;
          end else if (r30) begin
            nxt = NS_YELLOW;
          end
        end
        NS_YELLOW: if (r45) nxt = EW_GREEN;
        EW_GREEN: begin
          if (r45) begin
            nxt       = NS_GREEN;
            fault_set = 1'b1;
          end else if (r30) begin
            nxt = EW_YELLOW;
          end
        end
        EW_YELLOW: begin
          if (r45) begin
            nxt     = NS_GREEN;
            cyc_inc = 1'b1;
          end
        end
        ALL_RED: if (r45) nxt = NS_GREEN;
        NIGHT:   if (r45) nxt = ALL_RED;
        default: nxt = ALL_RED;
      endcase
      if (nxt == NIGHT) blink_nxt = ~blink;
    end
  end

  always_comb begin
    ns_light = RED;
    ew_light = RED;
    case (cur)
      NS_GREEN:  ns_light = GREEN;
      NS_YELLOW: ns_light = YELLOW;
      EW_GREEN:  ew_light = GREEN;
      EW_YELLOW: ew_light = YELLOW;
      NIGHT: begin
        ns_light = {1'b0, blink, 1'b0};
        ew_light = {1'b0, blink, 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: a countdown timer model for the normal
// cycle, manual timeout pulses for edge cases, and a CYC_W=2 instance for wrap.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic night_mode = 1'b0;
  logic man45 = 1'b0;
  logic man30 = 1'b0;
  logic tmr_en = 1'b1;
  logic [5:0] cnt = 6'd44;
  logic timeout45, timeout30;

  logic [2:0] ns_light, ew_light, state;
  logic       seq_fault;
  logic [7:0] cycles;
  logic [2:0] ns2, ew2, state2;
  logic       fault2;
  logic [1:0] cycles2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst || cnt == 6'd0) cnt <= 6'd44;
    else                    cnt <= cnt - 6'd1;
  end

  assign timeout45 = tmr_en ? (cnt == 6'd0) : man45;
  assign timeout30 = tmr_en ? (cnt == 6'd5) : man30;

  traffic_light_ctrl dut (
    .clk(clk), .rst(rst), .timeout45(timeout45), .timeout30(timeout30),
    .night_mode(night_mode), .ns_light(ns_light), .ew_light(ew_light),
    .state(state), .seq_fault(seq_fault), .cycles(cycles)
  );

  traffic_light_ctrl #(.CYC_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .timeout45(timeout45), .timeout30(timeout30),
    .night_mode(night_mode), .ns_light(ns2), .ew_light(ew2),
    .state(state2), .seq_fault(fault2), .cycles(cycles2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse45();
    man45 = 1'b1; step();
    man45 = 1'b0; step();
  endtask

  task automatic pulse30();
    man30 = 1'b1; step();
    man30 = 1'b0; step();
  endtask

  task automatic test_reset();
    rst = 1'b1; step();
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++;
    if (ns_light !== 3'b001 || ew_light !== 3'b100) begin
      errors++; $display("FAIL reset_lights got %b/%b exp 001/100", ns_light, ew_light);
    end
    checks++;
    if (seq_fault !== 1'b0 || cycles !== 8'd0) begin
      errors++; $display("FAIL reset_regs got fault %b cycles %0d exp 0/0", seq_fault, cycles);
    end
    rst = 1'b0;
  endtask

  task automatic test_normal_cycle();
    logic [2:0] e_ns, e_ew;
    logic [7:0] e_cyc;
    for (int i = 1; i <= 90; i++) begin
      step();
      if (i < 40)      begin e_ns = 3'b001; e_ew = 3'b100; end
      else if (i < 45) begin e_ns = 3'b010; e_ew = 3'b100; end
      else if (i < 85) begin e_ns = 3'b100; e_ew = 3'b001; end
      else if (i < 90) begin e_ns = 3'b100; e_ew = 3'b010; end
      else             begin e_ns = 3'b001; e_ew = 3'b100; end
      e_cyc = (i == 90) ? 8'd1 : 8'd0;
      checks++;
      if (ns_light !== e_ns || ew_light !== e_ew) begin
        errors++; $display("FAIL cycle_lights step %0d got %b/%b exp %b/%b", i, ns_light, ew_light, e_ns, e_ew);
      end
      checks++;
      if (cycles !== e_cyc || seq_fault !== 1'b0) begin
        errors++; $display("FAIL cycle_count step %0d got cycles %0d fault %b exp %0d/0", i, cycles, seq_fault, e_cyc);
      end
    end
    tmr_en = 1'b0;
  endtask

  task automatic test_held_level();
    pulse30();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL held_to_yellow got %0d exp 1", state); end
    man45 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (state !== 3'd2) begin errors++; $display("FAIL held45 clk %0d got %0d exp 2", k, state); end
    end
    man45 = 1'b0; step();
    checks++;
    if (state !== 3'd2 || seq_fault !== 1'b0) begin
      errors++; $display("FAIL held_release got state %0d fault %b exp 2/0", state, seq_fault);
    end
  endtask

  task automatic test_same_edge();
    man30 = 1'b1; man45 = 1'b1; step();
    checks++;
    if (state !== 3'd0 || ns_light !== 3'b001) begin
      errors++; $display("FAIL same_edge got state %0d ns %b exp 0/001", state, ns_light);
    end
    checks++;
    if (seq_fault !== 1'b1 || cycles !== 8'd1) begin
      errors++; $display("FAIL same_edge_regs got fault %b cycles %0d exp 1/1", seq_fault, cycles);
    end
    man30 = 1'b0; man45 = 1'b0; step();
  endtask

  task automatic test_skip_yellow();
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (seq_fault !== 1'b0 || cycles !== 8'd0) begin
      errors++; $display("FAIL skip_pre got fault %b cycles %0d exp 0/0", seq_fault, cycles);
    end
    man45 = 1'b1; step(); man45 = 1'b0;
    checks++;
    if (state !== 3'd2 || ew_light !== 3'b001 || seq_fault !== 1'b1) begin
      errors++; $display("FAIL skip_yellow got state %0d ew %b fault %b exp 2/001/1", state, ew_light, seq_fault);
    end
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (seq_fault !== 1'b1) begin errors++; $display("FAIL skip_sticky got %b exp 1", seq_fault); end
  endtask

  task automatic test_night();
    logic [2:0] e_l;
    night_mode = 1'b1;
    man45 = 1'b1; step(); man45 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e_l = (k % 2 == 0) ? 3'b010 : 3'b000;
      checks++;
      if (state !== 3'd5 || ns_light !== e_l || ew_light !== e_l) begin
        errors++; $display("FAIL night_blink clk %0d got state %0d %b/%b exp 5 %b", k, state, ns_light, ew_light, e_l);
      end
      step();
    end
    pulse30();
    checks++;
    if (state !== 3'd5) begin errors++; $display("FAIL night_r30 got %0d exp 5", state); end
    night_mode = 1'b0; step(); step();
    checks++;
    if (state !== 3'd5) begin errors++; $display("FAIL night_level got %0d exp 5", state); end
    pulse45();
    checks++;
    if (state !== 3'd4 || ns_light !== 3'b100 || ew_light !== 3'b100) begin
      errors++; $display("FAIL all_red got state %0d %b/%b exp 4 100/100", state, ns_light, ew_light);
    end
    pulse45();
    checks++;
    if (state !== 3'd0 || ns_light !== 3'b001 || ew_light !== 3'b100) begin
      errors++; $display("FAIL night_exit got state %0d %b/%b exp 0 001/100", state, ns_light, ew_light);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [1:0] e2;
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pulse30(); pulse45(); pulse30(); pulse45();
      e2 = 2'(k + 1);
      checks++;
      if (cycles2 !== e2 || state2 !== 3'd0) begin
        errors++; $display("FAIL wrap cycle %0d got %0d state %0d exp %0d/0", k, cycles2, state2, e2);
      end
    end
    checks++;
    if (cycles !== 8'd4 || seq_fault !== 1'b0) begin
      errors++; $display("FAIL wide_count got %0d fault %b exp 4/0", cycles, seq_fault);
    end
    pulse45();
    checks++;
    if (state !== 3'd2 || seq_fault !== 1'b1) begin
      errors++; $display("FAIL mid_ew got state %0d fault %b exp 2/1", state, seq_fault);
    end
    rst = 1'b1; man30 = 1'b1; man45 = 1'b1; night_mode = 1'b1; step();
    rst = 1'b0; man30 = 1'b0; man45 = 1'b0; night_mode = 1'b0;
    checks++;
    if (state !== 3'd0 || ns_light !== 3'b001 || cycles !== 8'd0 || seq_fault !== 1'b0) begin
      errors++; $display("FAIL rst_override got state %0d ns %b cycles %0d fault %b exp 0/001/0/0", state, ns_light, cycles, seq_fault);
    end
    checks++;
    if (cycles2 !== 2'd0 || fault2 !== 1'b0) begin
      errors++; $display("FAIL rst_narrow got cycles %0d fault %b exp 0/0", cycles2, fault2);
    end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_held_level();
    test_same_edge();
    test_skip_yellow();
    test_night();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
